// File: rtl/audio_stream_pkg.sv
`default_nettype none
// ============================================================================
// audio_stream_pkg: shared states, default geometry and half-select helpers
// Rev 1.0
// ============================================================================
package audio_stream_pkg;

  localparam int                    c_ADDR_W   = 23;
  localparam logic [c_ADDR_W-1:0]   c_MAX_ADDR = 23'h7FFFF;

  localparam logic c_HALF_LO = 1'b0;
  localparam logic c_HALF_HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    REQ         = 3'd1,
    WAIT_FLASH  = 3'd2,
    WAIT_TICK_A = 3'd3,
    OUT_A       = 3'd4,
    WAIT_TICK_B = 3'd5,
    OUT_B       = 3'd6,
    ADVANCE     = 3'd7
  } state_t;

  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic sel);
    return (sel == c_HALF_HI) ? word[31:16] : word[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_stream_fsm_if.sv
`default_nettype none
// ============================================================================
// audio_stream_fsm_if: request/finish handshake to the flash word reader
// Rev 1.0
// ============================================================================
interface audio_stream_fsm_if #(
  parameter int ADDR_W = audio_stream_pkg::c_ADDR_W
);
  logic              flash_start;
  logic [ADDR_W-1:0] flash_address;
  logic              flash_finish;
  logic [31:0]       flash_readdata;

  modport master (
    output flash_start,
    output flash_address,
    input  flash_finish,
    input  flash_readdata
  );

  modport slave (
    input  flash_start,
    input  flash_address,
    output flash_finish,
    output flash_readdata
  );
endinterface
`default_nettype wire

// File: rtl/audio_addr_ctr.sv
`default_nettype none
// ============================================================================
// audio_addr_ctr: up/down word address counter wrapping between 0 and MAX_ADDR
// Rev 1.0
// ============================================================================
module audio_addr_ctr
  import audio_stream_pkg::*;
#(
  parameter int                ADDR_W   = c_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = c_MAX_ADDR
) (
  input  wire logic              CLK_50M,
  input  wire logic              reset,
  input  wire logic              i_load,
  input  wire logic [ADDR_W-1:0] i_load_addr,
  input  wire logic              i_step,
  input  wire logic              i_up,
  output logic      [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

  // Load wins over step so a restart never races an advance.
  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_addr;
    end else if (i_step) begin
      if (i_up) begin
        r_addr <= (r_addr == MAX_ADDR) ? '0 : r_addr + 1'b1;
      end else begin
        r_addr <= (r_addr == '0) ? MAX_ADDR : r_addr - 1'b1;
      end
    end
  end

  assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/audio_stream_fsm.sv
`default_nettype none
// ============================================================================
// audio_stream_fsm: fetches 32-bit flash words and plays them as two 16-bit
// samples per word, forward or backward. Rev 1.0
// ============================================================================
module audio_stream_fsm
  import audio_stream_pkg::*;
#(
  parameter int                ADDR_W   = c_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = c_MAX_ADDR
) (
  input  wire logic          CLK_50M,
  input  wire logic          reset,
  input  wire logic          sample_tick,
  input  wire logic          play,
  input  wire logic          direction,
  input  wire logic          restart,
  audio_stream_fsm_if.master flash,
  output logic      [15:0]   audio_sample,
  output logic               audio_valid,
  output logic               underrun
);

  state_t            r_state;
  logic [31:0]       r_word;
  logic              r_dir_cap;
  logic              r_restart_pending;
  logic              r_flash_start;
  logic [15:0]       r_audio_sample;
  logic              r_audio_valid;
  logic              r_underrun;

  logic              w_tick;
  logic              w_in_tick_state;
  logic              w_restart_req;
  logic              w_do_restart;
  logic              w_ctr_step;
  logic [ADDR_W-1:0] w_restart_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              w_sel_a;

  assign w_tick          = sample_tick & play;
  assign w_in_tick_state = (r_state == WAIT_TICK_A) || (r_state == WAIT_TICK_B);
  assign w_restart_req   = restart | r_restart_pending;
  // A restart only lands where no read is in flight, or as the pending read completes.
  assign w_do_restart    = w_restart_req &&
                           ((r_state == IDLE) || w_in_tick_state || (r_state == ADVANCE) ||
                            ((r_state == WAIT_FLASH) && flash.flash_finish));
  assign w_ctr_step      = (r_state == ADVANCE) && !w_restart_req;
  assign w_restart_addr  = direction ? '0 : MAX_ADDR;
  assign w_sel_a         = r_dir_cap ? c_HALF_LO : c_HALF_HI;

  audio_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_addr_ctr (
    .CLK_50M     (CLK_50M),
    .reset       (reset),
    .i_load      (w_do_restart),
    .i_load_addr (w_restart_addr),
    .i_step      (w_ctr_step),
    .i_up        (direction),
    .o_addr      (w_addr)
  );

  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_word            <= '0;
      r_dir_cap         <= 1'b1;
      r_restart_pending <= 1'b0;
      r_flash_start     <= 1'b0;
      r_audio_sample    <= '0;
      r_audio_valid     <= 1'b0;
      r_underrun        <= 1'b0;
    end else begin
      r_flash_start <= 1'b0;
      r_audio_valid <= 1'b0;
      r_underrun    <= w_tick && !restart && !w_in_tick_state;

      if (w_do_restart) begin
        r_state           <= REQ;
        r_flash_start     <= 1'b1;
        r_restart_pending <= 1'b0;
      end else begin
        if (restart) begin
          r_restart_pending <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            if (play) begin
              r_state       <= REQ;
              r_flash_start <= 1'b1;
            end
          end
          REQ: r_state <= WAIT_FLASH;
          WAIT_FLASH: begin
            if (flash.flash_finish) begin
              r_word    <= flash.flash_readdata;
              r_dir_cap <= direction;
              r_state   <= WAIT_TICK_A;
            end
          end
          WAIT_TICK_A: begin
            if (w_tick) begin
              r_audio_sample <= pick_half(r_word, w_sel_a);
              r_audio_valid  <= 1'b1;
              r_state        <= OUT_A;
            end
          end
          OUT_A: r_state <= WAIT_TICK_B;
          WAIT_TICK_B: begin
            if (w_tick) begin
              r_audio_sample <= pick_half(r_word, ~w_sel_a);
              r_audio_valid  <= 1'b1;
              r_state        <= OUT_B;
            end
          end
          OUT_B: r_state <= ADVANCE;
          ADVANCE: begin
            r_state       <= REQ;
            r_flash_start <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign flash.flash_start   = r_flash_start;
  assign flash.flash_address = w_addr;
  assign audio_sample        = r_audio_sample;
  assign audio_valid         = r_audio_valid;
  assign underrun            = r_underrun;

endmodule
`default_nettype wire
